// File: rtl/flag_ctrl_pkg.sv
// Shared definitions for the flag update controller.
// Flag bit positions, FSM encoding and default stack depth.
package flag_ctrl_pkg;

  localparam int FLAG_Z = 0;
  localparam int FLAG_S = 1;
  localparam int FLAG_C = 2;
  localparam int FLAG_W = 3;

  localparam int STACK_DEPTH_DEF = 4;

  typedef enum logic {
    IDLE    = 1'b0,
    RESTORE = 1'b1
  } state_t;

  function automatic logic [FLAG_W-1:0] mask_merge(
    input logic [FLAG_W-1:0] cur,
    input logic [FLAG_W-1:0] mask,
    input logic [FLAG_W-1:0] val
  );
    return (cur & ~mask) | (val & mask);
  endfunction

endpackage

// File: rtl/flag_update_ctrl_stack.sv
// LIFO shadow stack for saved flags.
// Caller guarantees push/pop are never issued when full/empty.
module flag_stack
  import flag_ctrl_pkg::*;
#(
  parameter int DEPTH = STACK_DEPTH_DEF,
  parameter int PTR_W = 2
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              push,
  input  logic              pop,
  input  logic [FLAG_W-1:0] wdata,
  output logic [FLAG_W-1:0] rdata,
  output logic [PTR_W:0]    depth,
  output logic              full,
  output logic              empty
);

  localparam logic [PTR_W:0] FULL_CNT = (PTR_W+1)'(DEPTH);
  localparam logic [PTR_W:0] ONE = (PTR_W+1)'(1);

  logic [FLAG_W-1:0] mem [DEPTH];
  logic [PTR_W:0]    top;

  assign top   = depth - ONE;
  assign rdata = mem[top[PTR_W-1:0]];
  assign full  = (depth == FULL_CNT);
  assign empty = (depth == '0);

  always_ff @(posedge clk) begin
    if (push)
      mem[depth[PTR_W-1:0]] <= wdata;
  end

  always_ff @(posedge clk) begin
    if (rst)
      depth <= '0;
    else if (push)
      depth <= depth + ONE;
    else if (pop)
      depth <= top;
  end

endmodule

// File: rtl/flag_update_ctrl.sv
// Next-flag arbitration for the zf/sf/cf register bank,
// with interrupt save/restore through a shadow stack.
module flag_update_ctrl
  import flag_ctrl_pkg::*;
#(
  parameter int STACK_DEPTH = STACK_DEPTH_DEF,
  parameter int PTR_W       = 2
) (
  input  logic              clk,
  input  logic              clrn,
  input  logic [FLAG_W-1:0] cur_flags,
  input  logic              alu_we,
  input  logic [FLAG_W-1:0] alu_flags,
  input  logic              cmp_we,
  input  logic [FLAG_W-1:0] cmp_flags,
  input  logic              sw_we,
  input  logic [FLAG_W-1:0] sw_mask,
  input  logic [FLAG_W-1:0] sw_val,
  input  logic              irq_save,
  input  logic              irq_restore,
  output logic              zf,
  output logic              sf,
  output logic              cf,
  output logic              busy,
  output logic              upd_drop,
  output logic [PTR_W:0]    depth,
  output logic              stk_ovf,
  output logic              stk_unf,
  output logic              seq_err
);

  state_t            state;
  logic [FLAG_W-1:0] rd_flags;
  logic [FLAG_W-1:0] nxt;
  logic [FLAG_W-1:0] rdata;
  logic              full;
  logic              empty;
  logic              push;
  logic              pop;
  logic              idle;

  assign idle = !clrn && (state == IDLE);
  assign push = idle && irq_save && !full;
  assign pop  = idle && irq_restore && !irq_save && !empty;

  flag_stack #(
    .DEPTH (STACK_DEPTH),
    .PTR_W (PTR_W)
  ) u_stack (
    .clk   (clk),
    .rst   (clrn),
    .push  (push),
    .pop   (pop),
    .wdata (cur_flags),
    .rdata (rdata),
    .depth (depth),
    .full  (full),
    .empty (empty)
  );

  always_comb begin
    nxt      = cur_flags;
    busy     = 1'b0;
    upd_drop = 1'b0;
    if (clrn) begin
      nxt = '0;
    end else if (state == RESTORE) begin
      nxt      = rd_flags;
      busy     = 1'b1;
      upd_drop = sw_we | alu_we | cmp_we;
    end else begin
      priority case (1'b1)
        sw_we:   nxt = mask_merge(cur_flags, sw_mask, sw_val);
        alu_we:  nxt = alu_flags;
        cmp_we:  nxt = cmp_flags;
        default: nxt = cur_flags;
      endcase
      upd_drop = (sw_we & alu_we) | (sw_we & cmp_we)
               | (alu_we & cmp_we);
    end
  end

  assign zf = nxt[FLAG_Z];
  assign sf = nxt[FLAG_S];
  assign cf = nxt[FLAG_C];

  always_ff @(posedge clk) begin
    if (clrn) begin
      state    <= IDLE;
      rd_flags <= '0;
      stk_ovf  <= 1'b0;
      stk_unf  <= 1'b0;
      seq_err  <= 1'b0;
    end else begin
      unique case (state)
        IDLE: begin
          if (irq_save && full)
            stk_ovf <= 1'b1;
          if (irq_save && irq_restore) begin
            seq_err <= 1'b1;
          end else if (irq_restore) begin
            if (empty) begin
              stk_unf <= 1'b1;
            end else begin
              rd_flags <= rdata;
              state    <= RESTORE;
            end
          end
        end
        RESTORE: begin
          if (irq_save || irq_restore)
            seq_err <= 1'b1;
          state <= IDLE;
        end
        default: state <= IDLE;
      endcase
    end
  end

endmodule
